// File: rtl/vertex_xform_sched.sv
// Vertex transform sequencer: streams vertices from BRAM into the transform pipe
// under a result-FIFO credit scheme and buffers index-tagged results.

module vertex_xform_sched_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic full
);
  // The credit scheme reserves space for every in-flight vertex, so a full write is a design bug.
  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

module vertex_xform_sched #(
  parameter int ADDR_W     = 12,
  parameter int BRAM_LAT   = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_verts,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] vtx_addr,
  output logic              vtx_en,
  input  logic [95:0]       vtx_data,
  output logic [3:0][31:0]  xf_pos,
  output logic              xf_v_in,
  input  logic [3:0][31:0]  xf_new_pos,
  input  logic              xf_v_out,
  output logic [127:0]      res_data,
  output logic [ADDR_W-1:0] res_idx,
  output logic              res_valid,
  input  logic              res_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_r, state_nx;
  logic [ADDR_W-1:0]   num_r, num_nx, cnt_r, cnt_base_s, ret_r, vtx_addr_r;
  logic [CW-1:0]       credits_r, crd_avail_s;
  logic                vtx_en_r, issue_nx;
  logic [BRAM_LAT-1:0] pipe_r, shift_s;
  logic [3:0][31:0]    xf_pos_r;
  logic [PW:0]         wp_r, rp_r;
  logic [127+ADDR_W:0] mem_r [FIFO_DEPTH];
  logic [127+ADDR_W:0] head_s;
  logic                push_s, pop_s, full_s, accept_s;

  assign accept_s = (state_r == IDLE) && start;
  assign push_s   = xf_v_out && (state_r != IDLE);
  assign pop_s    = res_valid && res_ready;
  assign full_s   = (wp_r[PW] != rp_r[PW]) && (wp_r[PW-1:0] == rp_r[PW-1:0]);
  // The last shift stage is xf_v_in itself; its input bit tells when vtx_data is to be captured.
  assign shift_s  = (pipe_r << 1) | BRAM_LAT'(vtx_en_r);

  // Next state plus one-cycle look-ahead issue decision, so vtx_en/vtx_addr come straight from flops.
  always_comb begin
    state_nx    = state_r;
    num_nx      = num_r;
    cnt_base_s  = cnt_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          num_nx     = num_verts;
          cnt_base_s = {ADDR_W{1'b0}};
          state_nx   = (num_verts == {ADDR_W{1'b0}}) ? DONE : RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        if ((cnt_r == num_r) && !vtx_en_r && (pipe_r == {BRAM_LAT{1'b0}})) begin
          state_nx = DRAIN;
        end else begin
          state_nx = RUN;
        end
      end
      DRAIN: begin
        if ((ret_r == num_r) && (wp_r == rp_r)) begin
          state_nx = DONE;
        end else begin
          state_nx = DRAIN;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    crd_avail_s = credits_r + CW'(pop_s);
    issue_nx    = (state_nx == RUN) && (cnt_base_s < num_nx) && (crd_avail_s != {CW{1'b0}});
  end

  // Control, credit, issue-pipe and FIFO pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      num_r      <= {ADDR_W{1'b0}};
      cnt_r      <= {ADDR_W{1'b0}};
      ret_r      <= {ADDR_W{1'b0}};
      credits_r  <= CW'(FIFO_DEPTH);
      vtx_en_r   <= 1'b0;
      vtx_addr_r <= {ADDR_W{1'b0}};
      pipe_r     <= {BRAM_LAT{1'b0}};
      xf_pos_r   <= 128'h0;
      wp_r       <= {(PW+1){1'b0}};
      rp_r       <= {(PW+1){1'b0}};
    end else begin
      state_r    <= state_nx;
      num_r      <= num_nx;
      cnt_r      <= cnt_base_s + ADDR_W'(issue_nx);
      credits_r  <= crd_avail_s - CW'(issue_nx);
      vtx_en_r   <= issue_nx;
      vtx_addr_r <= issue_nx ? cnt_base_s : vtx_addr_r;
      pipe_r     <= shift_s;
      if (shift_s[BRAM_LAT-1]) begin
        xf_pos_r <= {vtx_data, 32'h3f80_0000};
      end
      ret_r      <= accept_s ? {ADDR_W{1'b0}} : ret_r + ADDR_W'(push_s);
      wp_r       <= wp_r + (PW+1)'(push_s);
      rp_r       <= rp_r + (PW+1)'(pop_s);
    end
  end

  // Result storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wp_r[PW-1:0]] <= {xf_new_pos, ret_r};
    end
  end

  assign head_s    = mem_r[rp_r[PW-1:0]];
  assign res_data  = head_s[ADDR_W +: 128];
  assign res_idx   = head_s[ADDR_W-1:0];
  assign res_valid = (wp_r != rp_r);
  assign busy      = (state_r != IDLE);
  assign done      = (state_r == DONE);
  assign vtx_en    = vtx_en_r;
  assign vtx_addr  = vtx_addr_r;
  assign xf_v_in   = pipe_r[BRAM_LAT-1];
  assign xf_pos    = xf_pos_r;

  vertex_xform_sched_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .full (full_s)
  );
endmodule

// File: tb/tb_vertex_xform_sched.sv
// Directed bench for vertex_xform_sched with a registered BRAM model and a
// fixed-latency transform model (result = bitwise inverse of the input vertex).

module tb_vertex_xform_sched;
  localparam int ADDR_W = 12;
  localparam int XLAT   = 20;

  logic              clk, rst, start, busy, done, vtx_en, xf_v_in, xf_v_out, res_valid, res_ready;
  logic [ADDR_W-1:0] num_verts, vtx_addr, res_idx;
  logic [95:0]       vtx_data, bram_q;
  logic [3:0][31:0]  xf_pos, xf_new_pos;
  logic [127:0]      res_data;
  logic [127:0]      xd [XLAT];
  logic              xv [XLAT];

  int n_chk = 0, n_err = 0;
  int n_en = 0, n_xv = 0, n_done = 0, n_pop = 0, max_out = 0;
  int en_base = 0, xv_base = 0, done_base = 0, pop_base = 0;
  bit all_en, seen;

  vertex_xform_sched #(.ADDR_W(ADDR_W), .BRAM_LAT(2), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_verts(num_verts), .busy(busy), .done(done),
    .vtx_addr(vtx_addr), .vtx_en(vtx_en), .vtx_data(vtx_data), .xf_pos(xf_pos),
    .xf_v_in(xf_v_in), .xf_new_pos(xf_new_pos), .xf_v_out(xf_v_out), .res_data(res_data),
    .res_idx(res_idx), .res_valid(res_valid), .res_ready(res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [95:0] vmem(input int idx);
    logic [31:0] v;
    v = 32'(idx);
    return {v, v << 8, v << 16};
  endfunction

  function automatic logic [127:0] exp_res(input int idx);
    return ~{vmem(idx), 32'h3f80_0000};
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // BRAM: one register stage, so data is sampled by the DUT two edges after vtx_en.
  always @(posedge clk) if (vtx_en) bram_q <= vmem(int'(vtx_addr));
  assign vtx_data = bram_q;

  // Fixed-latency transform sharing rst.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < XLAT; i++) xv[i] <= 1'b0;
    end else begin
      xv[0] <= xf_v_in;
      xd[0] <= ~xf_pos;
      for (int i = 1; i < XLAT; i++) begin
        xv[i] <= xv[i-1];
        xd[i] <= xd[i-1];
      end
    end
  end
  assign xf_v_out   = xv[XLAT-1];
  assign xf_new_pos = xd[XLAT-1];

  // Event counters and in-order result scoreboard.
  always @(negedge clk) begin
    if (vtx_en) n_en++;
    if (xf_v_in) n_xv++;
    if (done) n_done++;
    if (res_valid && res_ready) begin
      check_eq("pop_idx", 128'(res_idx), 128'(n_pop - pop_base));
      check_eq("pop_data", res_data, exp_res(n_pop - pop_base));
      n_pop++;
    end
    if ((n_en - en_base) - (n_pop - pop_base) > max_out) max_out = (n_en - en_base) - (n_pop - pop_base);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    en_base = n_en; xv_base = n_xv; done_base = n_done; pop_base = n_pop;
  endtask

  task automatic start_blk(input logic [ADDR_W-1:0] n);
    tick();
    num_verts = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    num_verts = 12'd5;
  endtask

  task automatic wait_done(input string tag, input int max);
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check_eq(tag, 128'(seen), 128'(1));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_verts = '0; res_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_out", 128'({done, vtx_en, xf_v_in, res_valid}), 128'(0));
    check_eq("rst_xf_pos", xf_pos, 128'(0));

    // Single vertex, pop held back until the result is visible.
    snap();
    start_blk(12'd1);
    @(negedge clk);
    check_eq("t1_vtx_en", 128'({vtx_en, busy}), 128'(2'b11));
    check_eq("t1_vtx_addr", 128'(vtx_addr), 128'(0));
    @(negedge clk);
    check_eq("t1_xf_v_in_early", 128'(xf_v_in), 128'(0));
    @(negedge clk);
    check_eq("t1_xf_v_in", 128'(xf_v_in), 128'(1));
    check_eq("t1_xf_pos", xf_pos, 128'h0000_0000_0000_0000_0000_0000_3f80_0000);
    for (int i = 0; i < 40 && !res_valid; i++) @(negedge clk);
    check_eq("t1_res_valid", 128'(res_valid), 128'(1));
    check_eq("t1_res_idx", 128'(res_idx), 128'(0));
    check_eq("t1_res_data", res_data, exp_res(0));
    tick(); res_ready = 1'b1;
    @(negedge clk);
    tick(); res_ready = 1'b0;
    @(negedge clk);
    check_eq("t1_empty_no_done", 128'({res_valid, done}), 128'(0));
    @(negedge clk);
    check_eq("t1_done", 128'({done, busy}), 128'(2'b11));
    @(negedge clk);
    check_eq("t1_idle", 128'({done, busy}), 128'(0));
    check_eq("t1_pops", 128'(n_pop - pop_base), 128'(1));

    // 40 vertices, free-flowing output: 16 back-to-back issues then a credit stall.
    snap();
    res_ready = 1'b1;
    start_blk(12'd40);
    all_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      all_en &= vtx_en;
    end
    check_eq("t2_burst16", 128'(all_en), 128'(1));
    @(negedge clk);
    check_eq("t2_stall", 128'(vtx_en), 128'(0));
    wait_done("t2_done_timeout", 600);
    tick(); @(negedge clk);
    check_eq("t2_pops", 128'(n_pop - pop_base), 128'(40));
    check_eq("t2_issues", 128'(n_en - en_base), 128'(40));
    check_eq("t2_xf_v_in", 128'(n_xv - xv_base), 128'(40));
    check_eq("t2_done_once", 128'(n_done - done_base), 128'(1));
    check_eq("t2_max_outstanding", 128'(max_out), 128'(16));

    // 40 vertices with the output blocked until around cycle 100.
    snap();
    res_ready = 1'b0;
    start_blk(12'd40);
    repeat (98) tick();
    @(negedge clk);
    check_eq("t3_issues_blocked", 128'(n_en - en_base), 128'(16));
    check_eq("t3_fifo_held", 128'({res_valid, vtx_en}), 128'(2'b10));
    tick(); res_ready = 1'b1;
    wait_done("t3_done_timeout", 600);
    tick(); @(negedge clk);
    check_eq("t3_pops", 128'(n_pop - pop_base), 128'(40));
    check_eq("t3_issues", 128'(n_en - en_base), 128'(40));

    // Empty block.
    snap();
    start_blk(12'd0);
    @(negedge clk);
    check_eq("t4_done", 128'({done, busy}), 128'(2'b11));
    @(negedge clk);
    check_eq("t4_idle", 128'({done, busy}), 128'(0));
    repeat (5) tick();
    check_eq("t4_no_reads", 128'((n_en - en_base) + (n_xv - xv_base)), 128'(0));
    check_eq("t4_done_once", 128'(n_done - done_base), 128'(1));

    // A second start during a block is ignored.
    snap();
    start_blk(12'd12);
    repeat (5) tick();
    num_verts = 12'd5; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check_eq("t5_busy", 128'(busy), 128'(1));
    wait_done("t5_done_timeout", 600);
    tick(); @(negedge clk);
    check_eq("t5_pops", 128'(n_pop - pop_base), 128'(12));
    check_eq("t5_issues", 128'(n_en - en_base), 128'(12));
    check_eq("t5_done_once", 128'(n_done - done_base), 128'(1));

    // Reset with 10 vertices in flight, then a fresh 3-vertex block.
    snap();
    start_blk(12'd10);
    repeat (12) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_eq("t6_rst_busy", 128'({busy, done, vtx_en, xf_v_in, res_valid}), 128'(0));
    check_eq("t6_rst_addr", 128'(vtx_addr), 128'(0));
    check_eq("t6_rst_xf_pos", xf_pos, 128'(0));
    tick(); rst = 1'b0;
    snap();
    repeat (40) tick();
    check_eq("t6_no_stray", 128'(n_pop - pop_base), 128'(0));
    snap();
    start_blk(12'd3);
    wait_done("t6_done_timeout", 200);
    tick(); @(negedge clk);
    check_eq("t6_pops", 128'(n_pop - pop_base), 128'(3));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
